uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue feeding the UART transmitter: buffers bytes written by the mux core and
//  launches them one at a time via tx_start/data_out. Waits for tx_done_tick between bytes.
//  Sits directly upstream of uart_tx, one instance per UART channel.
// PARAMETERS
//  DATA_BITS   8  width of one character; must match the transmitter
//  ADDR_BITS   4  log2 of queue depth (DEPTH = 2**ADDR_BITS = 16 entries)
// PORTS
//  clk           in   1            system clock, all logic on rising edge
//  reset_n       in   1            asynchronous, active-low reset
//  wr_en         in   1            write request; accepted when full==0
//  wr_data       in   DATA_BITS    byte to enqueue
//  full          out  1            queue holds DEPTH entries
//  empty         out  1            queue holds 0 entries
//  level         out  ADDR_BITS+1  number of stored entries, 0..DEPTH
//  cts           in   1            clear-to-send; 1 = launching new bytes permitted
//  tx_start      out  1            one-cycle launch pulse to transmitter
//  data_out      out  DATA_BITS    byte for transmitter; stable from tx_start until done
//  tx_done_tick  in   1            transmitter finished stop bit (one-cycle pulse)
//  busy          out  1            a byte is in flight (launched, done not yet seen)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, pointers/level 0, empty=1, full=0, tx_start=0,
//   busy=0, data_out=0. Queue contents are don't-care. Reset both this block and the
//   transmitter together; reset mid-byte discards the queued bytes and the in-flight byte.
//  Queue: circular buffer, wr_ptr/rd_ptr ADDR_BITS wide, wrap naturally modulo DEPTH.
//   level is ADDR_BITS+1 wide; full = (level==DEPTH), empty = (level==0), all registered.
//   Write while full is ignored: data dropped, no pointer/level change.
//   Simultaneous accepted write and pop: level unchanged, both pointers advance.
//   Write into an empty queue is not visible to the FSM until the next cycle (no bypass).
//  FSM (2 states):
//   IDLE: busy=0. If !empty && cts: data_out<=head, rd_ptr++, level--, tx_start<=1,
//         -> BUSY. Otherwise stay.
//   BUSY: busy=1, tx_start<=0 (pulse is exactly one cycle). On tx_done_tick -> IDLE.
//         cts is ignored in BUSY; a byte in flight always completes.
//   tx_done_tick seen in IDLE is ignored.
//  Latency: wr_en accepted at edge N into empty queue, cts=1 -> tx_start high after edge
//   N+1. After tx_done_tick at edge M, the next tx_start is high after edge M+1 (the
//   transmitter is back in IDLE by then).
//  cts deasserted: queued bytes are held; writes continue until full.
// CONFIGURATION
//  UART_TX_QUEUE_DROP_CNT_EN defined: extra output drop_count [7:0], reset 0, increments
//   on each wr_en while full, saturates at 255; never wraps.
//  Not defined: port absent; dropped writes are silent. No other behaviour changes.
// STRUCTURE
//  uart_defs.vh (shared include): FSM state localparams, default DATA_BITS.
//  Sub-module uart_fifo (sync FIFO: mem, pointers, level/full/empty, push/pop) is
//   natural and is reused by the receive path; uart_tx_queue = uart_fifo + launch FSM.
// TESTING
//  1. Write 0xA5 with cts=1 -> tx_start one cycle after write, data_out=0xA5, busy=1;
//     tx_done_tick -> busy=0, empty=1.
//  2. Write 16 bytes 0x00..0x0F, cts=0 -> full=1, level=16; 17th write 0xFF dropped
//     (drop_count=1 with macro); cts=1 -> 16 bytes launched in order 0x00..0x0F.
//  3. Write and launch in the same cycle with level=3 -> level stays 3, pointers advance.
//  4. Drive 40 bytes through with random done delay -> pointers wrap twice, order intact.
//  5. cts low mid-byte -> in-flight byte completes, no further tx_start until cts=1.
//  6. reset_n low while BUSY with level=5 -> immediately tx_start=0, busy=0, level=0,
//     empty=1; no tx_start after release until new write.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: launch FSM states and default sizes.
package uart_tx_queue_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_ADDR_BITS = 4;
  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_fifo.sv
// Synchronous circular-buffer FIFO with registered level/full/empty.
// Writes while full and pops while empty are ignored; the head is read combinationally.
module uart_tx_queue_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic [ADDR_BITS:0]   level,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
    level_d = level_q + (ADDR_BITS+1)'(push_ok) - (ADDR_BITS+1)'(pop_ok);
    full_d  = (level_d == DEPTH);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of uart_tx: buffers writes and launches one byte per tx_done_tick.
// Optional macro UART_TX_QUEUE_DROP_CNT_EN adds a saturating drop_count output.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   level,
  input  logic                 cts,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] data_out,
  input  logic                 tx_done_tick,
  output logic                 busy
`ifdef UART_TX_QUEUE_DROP_CNT_EN
  , output logic [7:0]         drop_count
`endif
);

  tx_state_e            state_q, state_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] head;
  logic                 pop;

  uart_tx_queue_fifo #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .wdata   (wr_data),
    .pop     (pop),
    .rdata   (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // cts only gates a new launch; once BUSY the byte always runs to tx_done_tick.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    data_d     = data_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && cts) begin
          pop        = 1'b1;
          data_d     = head;
          tx_start_d = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (tx_done_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      data_q     <= data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign data_out = data_q;
  assign busy     = (state_q == ST_BUSY);

`ifdef UART_TX_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_en && full && (drop_cnt_q != DROP_CNT_MAX)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: per-cycle vector table plus multi-cycle sequences.
module tb_uart_tx_queue;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       cts;
  logic       tx_start;
  logic [7:0] data_out;
  logic       tx_done_tick;
  logic       busy;
`ifdef UART_TX_QUEUE_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_queue #(.DATA_BITS(8), .ADDR_BITS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .cts          (cts),
    .tx_start     (tx_start),
    .data_out     (data_out),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    , .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       cts;
    logic       done;
    logic       st;
    logic       bsy;
    logic [4:0] lvl;
    logic       emp;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_done(input int dly);
    repeat (dly) step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  initial begin
    int wi, ri, cd, cyc;
    bit pend;
    logic [7:0] e;

    // Test 1 and test 3: single byte, then simultaneous write+launch at level 3.
    tv[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 8'hA5};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'hA5};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'hA5};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'hA5};
    tv[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5};
    tv[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'hA5};
    tv[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 8'hA5};
    tv[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 8'h11};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 8'h11};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 8'h11};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 8'h22};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 8'h22};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'h22};
    tv[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'h33};
    tv[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 8'h33};
    tv[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 8'h44};
    tv[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h44};

    reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; cts = 1'b0; tx_done_tick = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif

    for (int i = 0; i < 18; i++) begin
      wr_en = tv[i].wr; wr_data = tv[i].wd; cts = tv[i].cts; tx_done_tick = tv[i].done;
      step();
      chk($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(tv[i].st));
      chk($sformatf("vec%0d_busy", i),     32'(busy),     32'(tv[i].bsy));
      chk($sformatf("vec%0d_level", i),    32'(level),    32'(tv[i].lvl));
      chk($sformatf("vec%0d_empty", i),    32'(empty),    32'(tv[i].emp));
      chk($sformatf("vec%0d_full", i),     32'(full),     32'd0);
      chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(tv[i].dout));
    end
    wr_en = 1'b0; cts = 1'b0; tx_done_tick = 1'b0;

    // Test 2: fill to 16 with cts low, overflow write dropped, then drain in order.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    wr_en = 1'b1; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("drop_level", 32'(level), 32'd16);
    chk("drop_full",  32'(full),  32'd1);
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    chk("drop_count_1", 32'(drop_count), 32'd1);
    wr_en = 1'b1;
    repeat (260) step();
    wr_en = 1'b0;
    chk("drop_count_sat", 32'(drop_count), 32'd255);
    chk("drop_sat_level", 32'(level), 32'd16);
`endif
    cts = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("drain%0d_tx_start", i), 32'(tx_start), 32'd1);
      chk($sformatf("drain%0d_data", i),     32'(data_out), 32'(i));
      send_done(i % 3);
      chk($sformatf("drain%0d_idle", i),     32'(busy),     32'd0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step();
    chk("drain_no_start", 32'(tx_start), 32'd0);

    // Test 4: 40 bytes streamed with random completion delay; order must hold across wraps.
    wi = 0; ri = 0; cd = 0; cyc = 0; pend = 1'b0;
    cts = 1'b1;
    while ((ri < 40 || pend) && cyc < 3000) begin
      tx_done_tick = 1'b0;
      if (tx_start) begin
        e = 8'(ri + 128);
        chk($sformatf("stream%0d_data", ri), 32'(data_out), 32'(e));
        ri++;
        pend = 1'b1;
        cd = $urandom_range(0, 6);
      end
      if (pend) begin
        if (cd == 0) begin
          tx_done_tick = 1'b1;
          pend = 1'b0;
        end else cd--;
      end
      wr_en = (wi < 40) && !full;
      if (wr_en) begin
        wr_data = 8'(wi + 128);
        wi++;
      end
      step();
      cyc++;
    end
    wr_en = 1'b0; tx_done_tick = 1'b0;
    chk("stream_count", 32'(ri), 32'd40);
    chk("stream_empty", 32'(empty), 32'd1);

    // Test 5: cts dropped mid-byte; the in-flight byte completes, next waits for cts.
    cts = 1'b0;
    wr_en = 1'b1; wr_data = 8'h5A; step();
    wr_data = 8'h6B; step();
    wr_en = 1'b0; cts = 1'b1;
    step();
    chk("cts_launch1", 32'(tx_start), 32'd1);
    chk("cts_data1",   32'(data_out), 32'h5A);
    cts = 1'b0;
    step();
    chk("cts_busy_held", 32'(busy), 32'd1);
    send_done(0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("cts_hold%0d_start", i), 32'(tx_start), 32'd0);
      chk($sformatf("cts_hold%0d_level", i), 32'(level),    32'd1);
    end
    cts = 1'b1;
    step();
    chk("cts_launch2", 32'(tx_start), 32'd1);
    chk("cts_data2",   32'(data_out), 32'h6B);
    cts = 1'b0;
    send_done(1);
    chk("cts_final_busy",  32'(busy),  32'd0);
    chk("cts_final_empty", 32'(empty), 32'd1);

    // Test 6: asynchronous reset while BUSY with 5 bytes still queued.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
      step();
    end
    wr_en = 1'b0; cts = 1'b1;
    step();
    chk("pre_rst_start", 32'(tx_start), 32'd1);
    chk("pre_rst_level", 32'(level),    32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_busy",     32'(busy),     32'd0);
    chk("arst_level",    32'(level),    32'd0);
    chk("arst_empty",    32'(empty),    32'd1);
    chk("arst_data_out", 32'(data_out), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst%0d_start", i), 32'(tx_start), 32'd0);
    end
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    chk("post_rst_launch", 32'(tx_start), 32'd1);
    chk("post_rst_data",   32'(data_out), 32'h3C);
    send_done(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
